sandbox_host_link: RTL and testbench
====================================

SANDBOX_HOST_LINK -- requirements
Module: sandbox_host_link

Interface
REQ-001 Parameter RX_TIMEOUT, default 1000000, is the number of idle cycles after which a partially received frame is discarded.
REQ-002 Ports:
  - masterClock  in  1  operating clock.
  - reset        in  1  asynchronous, active-low reset.
  - rxValid      in  1  one-cycle strobe: rxByte holds a byte from the host link.
  - rxByte       in  8  received byte.
  - txReady      in  1  the byte transmitter can accept a byte.
  - txValid      out 1  one-cycle strobe presenting txByte to the transmitter.
  - txByte       out 8  byte to send to the host.
  - dataReceived out 1  a command is present for the sandbox process.
  - control      out 8  command control byte.
  - inputData    out 32 command data word.
  - clearDR      in  1  the process has consumed the command.
  - transmitData in  1  the process presents a result.
  - status       in  8  the process status byte.
  - outputData   in 32  the process result word.
  - busy         out 1  high in every state except IDLE.
  - dropCount    out 8  saturating count of discarded rx bytes.
REQ-003 Clocking: one clock (masterClock); reset is asynchronous and active-low.

Function
REQ-004 Command frame: 5 bytes, in order control, inputData[7:0], [15:8], [23:16], [31:24].
REQ-005 Response frame: 5 bytes, in order status, outputData[7:0], [15:8], [23:16], [31:24].
REQ-006 States: IDLE, RX_COLLECT, DELIVER, WAIT_RELEASE, TX_SEND.
REQ-007 IDLE: an rxValid byte is stored as control, the byte index is set to 1, and the state becomes RX_COLLECT.
REQ-008 RX_COLLECT:
  - each rxValid byte is stored at the current byte index, and the index increments;
  - storing index 4 moves to DELIVER on the next cycle.
REQ-009 RX_COLLECT idle counter:
  - clears on every rxValid;
  - on reaching RX_TIMEOUT the partial frame is discarded, dropCount increments, and the state returns to IDLE.
REQ-010 DELIVER: dataReceived=1; control and inputData are held stable until dataReceived falls.
REQ-011 Result capture (DELIVER only): on the first cycle with transmitData=1, status and outputData are latched and a captured flag is set; later changes are ignored.
REQ-012 A cycle in DELIVER with clearDR=1 drives dataReceived=0 on the next edge, and the state becomes WAIT_RELEASE.
REQ-013 WAIT_RELEASE exit, once transmitData=0 and clearDR=0:
  - captured flag set: go to TX_SEND;
  - captured flag clear: go to IDLE, with no response and dropCount incremented.
REQ-014 No new dataReceived assertion occurs before the exit in REQ-013.
REQ-015 TX_SEND:
  - each cycle with txReady=1 emits one txValid pulse with the next response byte;
  - txValid is never high on two consecutive cycles;
  - after byte 4, the captured flag clears and the state returns to IDLE.
REQ-016 rxValid bytes arriving in DELIVER, WAIT_RELEASE or TX_SEND are discarded, and each increments dropCount.
REQ-017 dropCount saturates at 255 and never wraps.
REQ-018 An rxValid that coincides with the RX_TIMEOUT expiry cycle is discarded as well, so dropCount increases by 2 (saturating).
REQ-019 When clearDR and transmitData first rise in the same DELIVER cycle, the capture happens in that cycle and REQ-012 applies.

Reset
REQ-020 While reset=0, all state is forced asynchronously:
  - state=IDLE, dataReceived=0, txValid=0, txByte=0, control=0, inputData=0, busy=0, dropCount=0;
  - byte index, idle counter and captured flag cleared.
REQ-021 Reset asserted mid-frame or mid-transmission abandons the operation; after release, no partial bytes are sent and no stale dataReceived is asserted.

Verification
REQ-022 Normal transaction:
  - stimulus: bytes 01,11,22,33,44; the process answers transmitData then clearDR with status=01, outputData=0xA5000000;
  - required: control=01, inputData=0x44332211, dataReceived falls one cycle after clearDR;
  - required: tx sends 01,00,00,00,A5 after transmitData=0 and clearDR=0.
REQ-023 Timeout (RX_TIMEOUT=16):
  - stimulus: bytes 01,02, then 16 idle cycles;
  - required: return to IDLE, dropCount=1, dataReceived never asserted;
  - required: the next 5-byte frame is delivered correctly.
REQ-024 Bytes while busy: 3 rxValid bytes during DELIVER -> dropCount=3, control and inputData unchanged.
REQ-025 Transmitter backpressure:
  - stimulus: txReady low for 10 cycles between each response byte;
  - required: exactly 5 txValid pulses in frame order, none consecutive.
REQ-026 Protocol variants:
  - clearDR without transmitData -> no tx bytes, dropCount increments;
  - simultaneous first transmitData and clearDR -> full response sent.
REQ-027 Mid-operation reset: reset pulsed low during TX_SEND after byte 2 -> no further txValid, all outputs at reset values, and the next frame is handled normally.

Source files
------------

// File: rtl/sandbox_host_link_if.sv
// Host link bundle: rx byte stream, tx byte stream and the
// command/result handshake with the sandbox process.
interface sandbox_host_link_if;
  logic        rxValid;
  logic [7:0]  rxByte;
  logic        txReady;
  logic        txValid;
  logic [7:0]  txByte;
  logic        dataReceived;
  logic [7:0]  control;
  logic [31:0] inputData;
  logic        clearDR;
  logic        transmitData;
  logic [7:0]  status;
  logic [31:0] outputData;
  logic        busy;
  logic [7:0]  dropCount;

  modport master (
    input  rxValid, rxByte, txReady,
    input  clearDR, transmitData,
    input  status, outputData,
    output txValid, txByte,
    output dataReceived, control, inputData,
    output busy, dropCount
  );

  modport slave (
    output rxValid, rxByte, txReady,
    output clearDR, transmitData,
    output status, outputData,
    input  txValid, txByte,
    input  dataReceived, control, inputData,
    input  busy, dropCount
  );
endinterface

// File: rtl/sandbox_host_link.sv
// Bridges 5-byte host command frames to a sandbox process
// and returns its 5-byte result frame over the byte transmitter.
module sandbox_host_link #(
  parameter int RX_TIMEOUT = 1000000
) (
  input logic masterClock,
  input logic reset,
  sandbox_host_link_if.master link
);
  localparam int CW = $clog2(RX_TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT = CW'(RX_TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [2:0] {
    IDLE, RX_COLLECT, DELIVER, WAIT_RELEASE, TX_SEND
  } state_t;

  state_t state, stateNext;

  logic [2:0]    byteIdx;
  logic [2:0]    txIdx;
  logic [CW-1:0] idleCnt;
  logic          captured;
  logic [7:0]    statusReg;
  logic [31:0]   resultReg;
  logic [7:0]    control;
  logic [31:0]   inputData;
  logic          txValid;
  logic [7:0]    txByte;
  logic [7:0]    dropCount;

  logic       expire;
  logic       releaseOk;
  logic       txFire;
  logic       lastTx;
  logic       busyDrop;
  logic [1:0] dropInc;
  logic [8:0] dropSum;
  logic [7:0] respByte;

  assign expire = (state == RX_COLLECT) &&
                  (idleCnt == TIMEOUT);
  assign releaseOk = (state == WAIT_RELEASE) &&
                     !link.transmitData && !link.clearDR;
  assign txFire = (state == TX_SEND) &&
                  link.txReady && !txValid;
  assign lastTx = (txIdx == 3'd4);
  assign busyDrop = state inside
                    {DELIVER, WAIT_RELEASE, TX_SEND};

  // Discards this cycle: timeout, unanswered command, stray bytes.
  always_comb begin
    dropInc = 2'd0;
    if (expire || (releaseOk && !captured))
      dropInc = 2'd1;
    if (link.rxValid && (expire || busyDrop))
      dropInc = dropInc + 2'd1;
    dropSum = {1'b0, dropCount} + {7'd0, dropInc};
  end

  // Response byte selected by the transmit index.
  always_comb begin
    respByte = 8'h00;
    case (txIdx)
      3'd0: respByte = statusReg;
      3'd1: respByte = resultReg[7:0];
      3'd2: respByte = resultReg[15:8];
      3'd3: respByte = resultReg[23:16];
      3'd4: respByte = resultReg[31:24];
      default: respByte = 8'h00;
    endcase
  end

  // Next-state logic.
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:
        if (link.rxValid) stateNext = RX_COLLECT;
      RX_COLLECT:
        if (expire)
          stateNext = IDLE;
        else if (link.rxValid && byteIdx == 3'd4)
          stateNext = DELIVER;
      DELIVER:
        if (link.clearDR) stateNext = WAIT_RELEASE;
      WAIT_RELEASE:
        if (releaseOk)
          stateNext = captured ? TX_SEND : IDLE;
      TX_SEND:
        if (txFire && lastTx) stateNext = IDLE;
      default:
        stateNext = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge masterClock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  // Command frame assembly; frozen outside IDLE/RX_COLLECT.
  always_ff @(posedge masterClock or negedge reset) begin
    if (!reset) begin
      control   <= 8'h00;
      inputData <= 32'h0;
      byteIdx   <= 3'd0;
    end else if (state == IDLE && link.rxValid) begin
      control <= link.rxByte;
      byteIdx <= 3'd1;
    end else if (state == RX_COLLECT && link.rxValid
                 && !expire) begin
      case (byteIdx)
        3'd1: inputData[7:0]   <= link.rxByte;
        3'd2: inputData[15:8]  <= link.rxByte;
        3'd3: inputData[23:16] <= link.rxByte;
        3'd4: inputData[31:24] <= link.rxByte;
        default: ;
      endcase
      byteIdx <= byteIdx + 3'd1;
    end
  end

  // Idle counter for a partially received frame; holds at expiry.
  always_ff @(posedge masterClock or negedge reset) begin
    if (!reset)
      idleCnt <= '0;
    else if (state != RX_COLLECT || link.rxValid)
      idleCnt <= '0;
    else if (idleCnt != TIMEOUT)
      idleCnt <= idleCnt + CNT_ONE;
  end

  // First result presented during DELIVER wins.
  always_ff @(posedge masterClock or negedge reset) begin
    if (!reset) begin
      captured  <= 1'b0;
      statusReg <= 8'h00;
      resultReg <= 32'h0;
    end else if (state == DELIVER && link.transmitData
                 && !captured) begin
      captured  <= 1'b1;
      statusReg <= link.status;
      resultReg <= link.outputData;
    end else if (txFire && lastTx) begin
      captured <= 1'b0;
    end
  end

  // Response transmit; a pulse is never followed by another.
  always_ff @(posedge masterClock or negedge reset) begin
    if (!reset) begin
      txValid <= 1'b0;
      txByte  <= 8'h00;
      txIdx   <= 3'd0;
    end else begin
      txValid <= txFire;
      if (txFire) begin
        txByte <= respByte;
        txIdx  <= lastTx ? 3'd0 : txIdx + 3'd1;
      end
    end
  end

  // Saturating discard counter.
  always_ff @(posedge masterClock or negedge reset) begin
    if (!reset)          dropCount <= 8'h00;
    else if (dropSum[8]) dropCount <= 8'hFF;
    else                 dropCount <= dropSum[7:0];
  end

  assign link.txValid      = txValid;
  assign link.txByte       = txByte;
  assign link.control      = control;
  assign link.inputData    = inputData;
  assign link.dataReceived = (state == DELIVER);
  assign link.busy         = (state != IDLE);
  assign link.dropCount    = dropCount;
endmodule

// File: tb/tb_sandbox_host_link.sv
// Directed bench for sandbox_host_link with a frame-level
// model: expected deliveries, response byte queue, drop count.
module tb_sandbox_host_link;
  logic masterClock = 1'b0;
  logic reset = 1'b0;

  sandbox_host_link_if link();

  sandbox_host_link #(.RX_TIMEOUT(16)) dut (
    .masterClock(masterClock),
    .reset(reset),
    .link(link)
  );

  always #5 masterClock = ~masterClock;

  int total = 0;
  int bad = 0;
  logic [7:0]  expTx[$];
  logic [7:0]  expCtrl = 8'h00;
  logic [31:0] expData = 32'h0;
  bit          expValid = 1'b0;
  int          expDrop = 0;
  int          txPulses = 0;
  bit          prevTx = 1'b0;

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic int satDrop();
    return (expDrop > 255) ? 255 : expDrop;
  endfunction

  // Per-cycle comparison against the frame-level model.
  always @(negedge masterClock) begin
    if (reset) begin
      check("dataReceived", 32'(link.dataReceived),
            32'(expValid));
      if (link.dataReceived) begin
        check("control", 32'(link.control), 32'(expCtrl));
        check("inputData", link.inputData, expData);
      end
      if (link.txValid) begin
        txPulses++;
        check("tx spacing", 32'(prevTx), 32'd0);
        if (expTx.size() == 0) begin
          total++;
          bad++;
          $display("FAIL tx unexpected: got %h want none",
                   link.txByte);
        end else begin
          check("tx byte", 32'(link.txByte),
                32'(expTx.pop_front()));
        end
      end
      prevTx = link.txValid;
    end else begin
      prevTx = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge masterClock);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] b);
    link.rxValid = 1'b1;
    link.rxByte  = b;
    tick();
    link.rxValid = 1'b0;
  endtask

  task automatic sendFrame(input logic [7:0] b0, b1, b2,
                           b3, b4);
    expCtrl = b0;
    expData = {b4, b3, b2, b1};
    sendByte(b0);
    sendByte(b1);
    sendByte(b2);
    sendByte(b3);
    sendByte(b4);
    expValid = 1'b1;
  endtask

  // mode 0: transmitData then clearDR (with a late data change)
  // mode 1: clearDR only; mode 2: both in the same cycle
  task automatic respond(input int mode, input logic [7:0] st,
                         input logic [31:0] od);
    link.status     = st;
    link.outputData = od;
    if (mode != 1) begin
      expTx.push_back(st);
      for (int i = 0; i < 4; i++)
        expTx.push_back(od[8*i +: 8]);
    end
    case (mode)
      0: begin
        link.transmitData = 1'b1;
        tick();
        link.status     = ~st;
        link.outputData = ~od;
        tick();
        link.transmitData = 1'b0;
        link.clearDR      = 1'b1;
        tick();
      end
      1: begin
        link.clearDR = 1'b1;
        tick();
        expDrop++;
      end
      default: begin
        link.transmitData = 1'b1;
        link.clearDR      = 1'b1;
        tick();
      end
    endcase
    expValid          = 1'b0;
    link.transmitData = 1'b0;
    link.clearDR      = 1'b0;
  endtask

  task automatic waitTxDone(string name);
    int n = 0;
    while ((expTx.size() != 0 || link.busy) && n < 200) begin
      tick();
      n++;
    end
    check({name, " tx drained"}, 32'(expTx.size()), 32'd0);
    check({name, " idle"}, 32'(link.busy), 32'd0);
  endtask

  task automatic checkReset(string name);
    check({name, " txValid"}, 32'(link.txValid), 32'd0);
    check({name, " txByte"}, 32'(link.txByte), 32'd0);
    check({name, " control"}, 32'(link.control), 32'd0);
    check({name, " inputData"}, link.inputData, 32'd0);
    check({name, " busy"}, 32'(link.busy), 32'd0);
    check({name, " dataReceived"},
          32'(link.dataReceived), 32'd0);
    check({name, " dropCount"}, 32'(link.dropCount), 32'd0);
  endtask

  task automatic pacedTx(input int count, string name);
    for (int k = 0; k < count; k++) begin
      int n = 0;
      link.txReady = 1'b1;
      while (!link.txValid && n < 30) begin
        tick();
        n++;
      end
      if (n >= 30) begin
        total++;
        bad++;
        $display("FAIL %s wait: got no txValid want pulse",
                 name);
      end
      link.txReady = 1'b0;
      repeat (10) tick();
    end
  endtask

  initial begin
    int p0;
    link.rxValid      = 1'b0;
    link.rxByte       = 8'h00;
    link.txReady      = 1'b1;
    link.clearDR      = 1'b0;
    link.transmitData = 1'b0;
    link.status       = 8'h00;
    link.outputData   = 32'h0;
    #2;
    checkReset("reset");
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // normal transaction
    p0 = txPulses;
    sendFrame(8'h01, 8'h11, 8'h22, 8'h33, 8'h44);
    check("t1 control", 32'(link.control), 32'h01);
    check("t1 inputData", link.inputData, 32'h44332211);
    respond(0, 8'h01, 32'hA5000000);
    check("t1 model b0", 32'(expTx[0]), 32'h01);
    check("t1 model b4", 32'(expTx[4]), 32'hA5);
    waitTxDone("t1");
    check("t1 pulses", 32'(txPulses - p0), 32'd5);
    check("t1 drop", 32'(link.dropCount), 32'd0);

    // rx timeout, then timeout coinciding with a byte
    sendByte(8'h01);
    sendByte(8'h02);
    repeat (16) tick();
    tick();
    tick();
    expDrop++;
    check("t2 idle", 32'(link.busy), 32'd0);
    check("t2 drop", 32'(link.dropCount), 32'd1);
    sendByte(8'h07);
    repeat (16) tick();
    sendByte(8'h09);
    expDrop += 2;
    tick();
    check("t2b idle", 32'(link.busy), 32'd0);
    check("t2b drop", 32'(link.dropCount), 32'd3);
    sendFrame(8'h5C, 8'hDE, 8'hAD, 8'hBE, 8'hEF);
    check("t2 inputData", link.inputData, 32'hEFBEADDE);
    respond(0, 8'h80, 32'h12345678);
    waitTxDone("t2");

    // bytes while busy
    sendFrame(8'h22, 8'h01, 8'h02, 8'h03, 8'h04);
    sendByte(8'hAA);
    sendByte(8'hBB);
    sendByte(8'hCC);
    expDrop += 3;
    tick();
    check("t3 drop", 32'(link.dropCount), 32'(satDrop()));
    check("t3 control", 32'(link.control), 32'h22);
    check("t3 inputData", link.inputData, 32'h04030201);
    respond(0, 8'h33, 32'hCAFEF00D);
    waitTxDone("t3");

    // transmitter backpressure
    sendFrame(8'h44, 8'h10, 8'h20, 8'h30, 8'h40);
    link.txReady = 1'b0;
    respond(0, 8'h55, 32'h87654321);
    p0 = txPulses;
    pacedTx(5, "t4");
    check("t4 pulses", 32'(txPulses - p0), 32'd5);
    waitTxDone("t4");
    link.txReady = 1'b1;

    // clearDR without result
    sendFrame(8'h66, 8'h00, 8'h00, 8'h00, 8'h01);
    respond(1, 8'h77, 32'h11111111);
    repeat (5) tick();
    check("t5 idle", 32'(link.busy), 32'd0);
    check("t5 drop", 32'(link.dropCount), 32'(satDrop()));

    // simultaneous transmitData and clearDR
    p0 = txPulses;
    sendFrame(8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC);
    respond(2, 8'h3C, 32'h0F1E2D4B);
    waitTxDone("t6");
    check("t6 pulses", 32'(txPulses - p0), 32'd5);

    // reset during transmission
    sendFrame(8'h12, 8'h34, 8'h56, 8'h78, 8'h9A);
    link.txReady = 1'b0;
    respond(0, 8'hE1, 32'hD4C3B2A1);
    pacedTx(3, "t7");
    reset = 1'b0;
    #1;
    checkReset("t7 reset");
    expTx.delete();
    expDrop = 0;
    tick();
    tick();
    reset = 1'b1;
    link.txReady = 1'b1;
    repeat (20) tick();
    check("t7 idle", 32'(link.busy), 32'd0);
    sendFrame(8'h02, 8'hA0, 8'hB0, 8'hC0, 8'hD0);
    respond(0, 8'h04, 32'h00C0FFEE);
    waitTxDone("t7");

    // dropCount saturation
    sendFrame(8'h31, 8'h41, 8'h51, 8'h61, 8'h71);
    repeat (260) sendByte(8'h5A);
    expDrop += 260;
    tick();
    check("t8 drop", 32'(link.dropCount), 32'd255);
    check("t8 inputData", link.inputData, 32'h71615141);
    respond(1, 8'h00, 32'h0);
    repeat (5) tick();
    check("t8 hold", 32'(link.dropCount), 32'(satDrop()));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
